// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants, FSM encoding, event type and scan-code lookup for the keyboard scan sequencer
package kbd_pkg;
    localparam int NUM_KEYS = 10;
    localparam int EVT_W    = 5;
    localparam logic [3:0] KEY_W     = 4'd0;
    localparam logic [3:0] KEY_A     = 4'd1;
    localparam logic [3:0] KEY_S     = 4'd2;
    localparam logic [3:0] KEY_D     = 4'd3;
    localparam logic [3:0] KEY_SPACE = 4'd4;
    localparam logic [3:0] KEY_UP    = 4'd5;
    localparam logic [3:0] KEY_LEFT  = 4'd6;
    localparam logic [3:0] KEY_DOWN  = 4'd7;
    localparam logic [3:0] KEY_RIGHT = 4'd8;
    localparam logic [3:0] KEY_ENTER = 4'd9;
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_ACK_HI  = 3'd2;
    localparam logic [2:0] S_ACK_LO  = 3'd3;
    localparam logic [2:0] S_DECODE  = 3'd4;
    typedef struct packed {
        logic       brk;
        logic [3:0] idx;
    } kbd_evt_t;
    // Returns {match, key_idx}; extended and plain code spaces never alias.
    function automatic logic [4:0] key_lookup(input logic [7:0] code, input logic ext);
        logic [4:0] r;
        r = 5'd0;
        if (ext) begin
            case (code)
                8'h75:   r = {1'b1, KEY_UP};
                8'h6B:   r = {1'b1, KEY_LEFT};
                8'h72:   r = {1'b1, KEY_DOWN};
                8'h74:   r = {1'b1, KEY_RIGHT};
                default: r = 5'd0;
            endcase
        end else begin
            case (code)
                8'h1D:   r = {1'b1, KEY_W};
                8'h1C:   r = {1'b1, KEY_A};
                8'h1B:   r = {1'b1, KEY_S};
                8'h23:   r = {1'b1, KEY_D};
                8'h29:   r = {1'b1, KEY_SPACE};
                8'h5A:   r = {1'b1, KEY_ENTER};
                default: r = 5'd0;
            endcase
        end
        return r;
    endfunction
endpackage

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: DEPTH-entry event FIFO with same-cycle push/pop and drop indication
//   clock50, reset_n (async active-low); push/din, pop/dout; full, empty; drop pulses when a push is refused
module kbd_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clock50,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         drop
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_pop, do_push;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full still lands.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/keyboard_scan_sequencer.sv
// keyboard_scan_sequencer: PS/2 scan-code handshake, E0/F0 decode, held-key tracking and event queue
//   clock50, reset_n (async active-low); scan_ready/scan_code in, read ack out;
//   key_state held keys; evt_valid/evt_data/evt_pop event FIFO; overflow, ack_err sticky flags.
//   Optional macro TYPEMATIC_FILTER_EN suppresses repeat makes and breaks of unheld keys.
module keyboard_scan_sequencer
    import kbd_pkg::*;
#(
    parameter int READ_PULSE  = 4,
    parameter int ACK_TIMEOUT = 255,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clock50,
    input  logic                reset_n,
    input  logic                scan_ready,
    input  logic [7:0]          scan_code,
    output logic                read,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                evt_valid,
    output logic [EVT_W-1:0]    evt_data,
    input  logic                evt_pop,
    output logic                overflow,
    output logic                ack_err
);
    localparam int CMAX = READ_PULSE > ACK_TIMEOUT ? READ_PULSE : ACK_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] RP_LAST = CW'(READ_PULSE - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(ACK_TIMEOUT - 1);
    logic [1:0]    sync;
    logic          rdy_s, armed, ext, brk, pfx, hit, push, drop, full, empty;
    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt;
    logic [7:0]    code;
    logic [4:0]    lk;
    kbd_evt_t      evt;
    assign rdy_s = sync[1];
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    state_n = (rdy_s && armed) ? S_CAPTURE : S_IDLE;
            S_CAPTURE: state_n = S_ACK_HI;
            S_ACK_HI:  state_n = (cnt == RP_LAST) ? S_ACK_LO : S_ACK_HI;
            S_ACK_LO:  state_n = (!rdy_s || cnt == TO_LAST) ? S_DECODE : S_ACK_LO;
            default:   state_n = S_IDLE;
        endcase
    end
    assign lk  = key_lookup(code, ext);
    assign pfx = code == SC_EXT || code == SC_BRK;
    assign hit = state == S_DECODE && !pfx && lk[4];
    assign evt = {brk, lk[3:0]};
`ifdef TYPEMATIC_FILTER_EN
    // Only report a real transition: make of a released key or break of a held one.
    assign push = hit && (key_state[lk[3:0]] == brk);
`else
    assign push = hit;
`endif
    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            sync      <= '0;
            state     <= S_IDLE;
            cnt       <= '0;
            read      <= 1'b0;
            armed     <= 1'b1;
            code      <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            key_state <= '0;
            overflow  <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            sync  <= {sync[0], scan_ready};
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + 1'b1;
            read  <= state_n == S_ACK_HI;
            // After a timeout scan_ready may still be high; wait for it to drop before the next capture.
            armed <= !rdy_s ? 1'b1 : (state == S_CAPTURE ? 1'b0 : armed);
            if (state == S_CAPTURE) code <= scan_code;
            if (state == S_ACK_LO && rdy_s && cnt == TO_LAST) ack_err <= 1'b1;
            if (drop) overflow <= 1'b1;
            if (state == S_DECODE) begin
                if (code == SC_EXT) ext <= 1'b1;
                else if (code == SC_BRK) brk <= 1'b1;
                else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (lk[4]) key_state[lk[3:0]] <= ~brk;
                end
            end
        end
    end
    kbd_event_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
        .clock50 (clock50),
        .reset_n (reset_n),
        .push    (push),
        .din     (evt),
        .pop     (evt_pop),
        .dout    (evt_data),
        .full    (full),
        .empty   (empty),
        .drop    (drop)
    );
    assign evt_valid = !empty;
endmodule

// File: tb/tb_keyboard_scan_sequencer.sv
// tb_keyboard_scan_sequencer: directed self-checking bench for keyboard_scan_sequencer
module tb_keyboard_scan_sequencer;
    logic       clock50 = 1'b0, reset_n = 1'b0, scan_ready = 1'b0, evt_pop = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       read, evt_valid, overflow, ack_err;
    logic [9:0] key_state;
    logic [4:0] evt_data;
    int total = 0, bad = 0;
`ifdef TYPEMATIC_FILTER_EN
    localparam int TYP_EVTS = 1;
    localparam int UNHELD_BRK = 0;
`else
    localparam int TYP_EVTS = 3;
    localparam int UNHELD_BRK = 1;
`endif
    always #10 clock50 = ~clock50;
    keyboard_scan_sequencer dut (
        .clock50    (clock50),
        .reset_n    (reset_n),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .read       (read),
        .key_state  (key_state),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_pop    (evt_pop),
        .overflow   (overflow),
        .ack_err    (ack_err)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic wait_read(input logic lvl);
        int n;
        n = 0;
        while (read !== lvl && n < 40) begin
            @(negedge clock50);
            n++;
        end
    endtask
    // Full handshake for one code; pop_at raises evt_pop in the cycle the event is pushed.
    task automatic send(input logic [7:0] c, input logic pop_at, output int hi);
        @(negedge clock50);
        scan_code  = c;
        scan_ready = 1'b1;
        wait_read(1'b1);
        hi = 0;
        while (read && hi < 40) begin
            @(negedge clock50);
            hi++;
        end
        scan_ready = 1'b0;
        repeat (3) @(negedge clock50);
        evt_pop = pop_at;
        @(negedge clock50);
        evt_pop = 1'b0;
        repeat (3) @(negedge clock50);
    endtask
    task automatic put(input logic [7:0] c);
        int h;
        send(c, 1'b0, h);
    endtask
    task automatic pop1;
        @(negedge clock50);
        evt_pop = 1'b1;
        @(negedge clock50);
        evt_pop = 1'b0;
    endtask
    task automatic do_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clock50);
        reset_n = 1'b1;
        @(negedge clock50);
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int h, n;
        logic [7:0] codes [5];
        codes = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29};
        repeat (3) @(negedge clock50);
        check("rst_read", read, 0);
        check("rst_keys", key_state, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_data", evt_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ackerr", ack_err, 0);
        reset_n = 1'b1;
        @(negedge clock50);
        send(8'h1D, 1'b0, h);
        check("read_pulse", h, 4);
        check("w_valid", evt_valid, 1);
        check("w_make", evt_data, 5'h00);
        check("w_held", key_state, 10'h001);
        pop1;
        check("pop_empty", evt_valid, 0);
        put(8'hF0);
        check("f0_noevt", evt_valid, 0);
        put(8'h1D);
        check("w_brk", evt_data, 5'h10);
        check("w_rel", key_state, 10'h000);
        pop1;
        put(8'hE0);
        put(8'h75);
        check("up_make", evt_data, 5'h05);
        check("up_held", key_state, 10'h020);
        pop1;
        put(8'hE0);
        put(8'hF0);
        put(8'h75);
        check("up_brk", evt_data, 5'h15);
        check("up_rel", key_state, 10'h000);
        pop1;
        put(8'h75);
        check("ext_clr", evt_valid, 0);
        put(8'h1C);
        check("a_valid", evt_valid, 1);
        check("brk_clr", evt_data, 5'h01);
        check("a_held", key_state, 10'h002);
        pop1;
        put(8'hF0);
        put(8'h1C);
        pop1;
        for (int i = 0; i < 5; i++) put(codes[i]);
        check("ovf_set", overflow, 1);
        check("ovf_keys", key_state, 10'h01F);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", evt_data, 32'(i));
            pop1;
        end
        check("ovf_empty", evt_valid, 0);
        @(negedge clock50);
        scan_code  = 8'h1D;
        scan_ready = 1'b1;
        wait_read(1'b1);
        check("mid_read_hi", read, 1);
        reset_n = 1'b0;
        #1;
        check("mid_read_drop", read, 0);
        check("mid_keys", key_state, 0);
        check("mid_valid", evt_valid, 0);
        check("mid_ovf", overflow, 0);
        scan_ready = 1'b0;
        repeat (2) @(negedge clock50);
        reset_n = 1'b1;
        @(negedge clock50);
        for (int i = 0; i < 4; i++) put(codes[i]);
        check("fill_no_ovf", overflow, 0);
        send(codes[4], 1'b1, h);
        check("full_pop_ovf", overflow, 0);
        check("full_pop_keys", key_state, 10'h01F);
        for (int i = 1; i < 5; i++) begin
            check("full_pop_drain", evt_data, 32'(i));
            pop1;
        end
        check("full_pop_empty", evt_valid, 0);
        put(8'h15);
        check("unknown_noevt", evt_valid, 0);
        put(8'hE0);
        put(8'h1D);
        check("fake_ext_noevt", evt_valid, 0);
        check("fake_ext_keys", key_state, 10'h01F);
        do_reset;
        for (int i = 0; i < 3; i++) put(8'h1D);
        n = 0;
        while (evt_valid && n < 8) begin
            pop1;
            n++;
        end
        check("typematic_cnt", n, TYP_EVTS);
        check("typematic_keys", key_state, 10'h001);
        put(8'hF0);
        put(8'h1C);
        check("unheld_brk", evt_valid, UNHELD_BRK);
        if (evt_valid) pop1;
        @(negedge clock50);
        scan_code  = 8'h1C;
        scan_ready = 1'b1;
        wait_read(1'b1);
        wait_read(1'b0);
        n = 0;
        while (!ack_err && n < 400) begin
            @(negedge clock50);
            n++;
        end
        check("ack_timeout", n, 255);
        check("ack_err", ack_err, 1);
        repeat (3) @(negedge clock50);
        check("ack_evt", evt_valid, 1);
        check("ack_data", evt_data, 5'h01);
        pop1;
        repeat (20) @(negedge clock50);
        check("no_recapture", evt_valid, 0);
        check("no_reread", read, 0);
        scan_ready = 1'b0;
        repeat (4) @(negedge clock50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
